ysyx_23060072_multdiv: RTL and testbench



---
 rtl/ysyx_23060072_multdiv_if.sv | 25 ++
 rtl/ysyx_23060072_multdiv.sv | 178 +++++++++++++++++
 tb/tb_ysyx_23060072_multdiv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060072_multdiv_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface ysyx_23060072_multdiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             clean_flag_i;
  logic             multdiv_hold_flag_o;
  logic             result_valid_o;
  logic [WIDTH-1:0] result_o;

  // EX stage side: issues operations, consumes stall and result
  modport master (
    output valid_i, op_i, rs1_data_i, rs2_data_i, clean_flag_i,
    input  multdiv_hold_flag_o, result_valid_o, result_o
  );

  // Multiply/divide unit side
  modport slave (
    input  valid_i, op_i, rs1_data_i, rs2_data_i, clean_flag_i,
    output multdiv_hold_flag_o, result_valid_o, result_o
  );
endinterface

// File: rtl/ysyx_23060072_multdiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a stall request to the controller.
module ysyx_23060072_multdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060072_multdiv_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic             is_div, a_signed, b_signed, sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             special;
  logic [WIDTH-1:0] special_val;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    prod_step, prod_fix;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] quot_step, rem_step, quot_fix, rem_fix;
  logic [WIDTH-1:0] res_fin;

  // Stall EX while an operation is being accepted or iterated
  assign bus.multdiv_hold_flag_o = bus.valid_i && !bus.clean_flag_i && (state_q != DONE);
  assign bus.result_valid_o      = result_valid_q;
  assign bus.result_o            = result_q;

  // Operand decode: signedness, magnitudes and divide corner cases
  always_comb begin
    is_div   = bus.op_i[2];
    a_signed = is_div ? !bus.op_i[0] : (bus.op_i[1:0] == 2'd1 || bus.op_i[1:0] == 2'd2);
    b_signed = is_div ? !bus.op_i[0] : (bus.op_i[1:0] == 2'd1);
    sign_a   = a_signed && bus.rs1_data_i[WIDTH-1];
    sign_b   = b_signed && bus.rs2_data_i[WIDTH-1];
    a_mag    = sign_a ? WIDTH'(0) - bus.rs1_data_i : bus.rs1_data_i;
    b_mag    = sign_b ? WIDTH'(0) - bus.rs2_data_i : bus.rs2_data_i;
    special     = 1'b0;
    special_val = '0;
    if (is_div && bus.rs2_data_i == '0) begin
      special     = 1'b1;
      special_val = bus.op_i[1] ? bus.rs1_data_i : ALL_ONES;
    end else if (is_div && !bus.op_i[0] && bus.rs1_data_i == MIN_NEG && bus.rs2_data_i == ALL_ONES) begin
      special     = 1'b1;
      special_val = bus.op_i[1] ? '0 : MIN_NEG;
    end
  end

  // One radix-2 step of each datapath plus sign-corrected final result
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {rem_q, quot_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      rem_step  = div_diff[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = div_shift[WIDTH-1:0];
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end
    prod_fix = neg_res_q ? PW'(0) - prod_step : prod_step;
    quot_fix = neg_res_q ? WIDTH'(0) - quot_step : quot_step;
    rem_fix  = neg_rem_q ? WIDTH'(0) - rem_step : rem_step;
    case (op_q)
      3'd0:          res_fin = prod_fix[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:          res_fin = prod_fix[PW-1:WIDTH];
      3'd4, 3'd5:    res_fin = quot_fix;
      default:       res_fin = rem_fix;
    endcase
  end

  // Next-state and next-register logic; flush overrides everything
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    neg_res_d      = neg_res_q;
    neg_rem_d      = neg_rem_q;
    a_d            = a_q;
    b_d            = b_q;
    prod_d         = prod_q;
    quot_d         = quot_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i && !bus.clean_flag_i) begin
          op_d      = bus.op_i;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          a_d       = a_mag;
          b_d       = b_mag;
          prod_d    = {{WIDTH{1'b0}}, b_mag};
          quot_d    = a_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (special) begin
            state_d        = DONE;
            result_d       = special_val;
            result_valid_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prod_d = prod_step;
        quot_d = quot_step;
        rem_d  = rem_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d        = DONE;
          result_d       = res_fin;
          result_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clean_flag_i) begin
      state_d        = IDLE;
      result_d       = result_q;
      result_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= '0;
      neg_res_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      prod_q         <= '0;
      quot_q         <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      neg_res_q      <= neg_res_d;
      neg_rem_q      <= neg_rem_d;
      a_q            <= a_d;
      b_q            <= b_d;
      prod_q         <= prod_d;
      quot_q         <= quot_d;
      rem_q          <= rem_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_multdiv.sv
// Scoreboard bench for the iterative multiply/divide unit.
module tb_ysyx_23060072_multdiv;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb_q[$];

  ysyx_23060072_multdiv_if #(.WIDTH(32)) bus ();

  ysyx_23060072_multdiv #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Pops one expectation per result pulse; any pulse without one is an error
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.result_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {31'b0, bus.result_valid_o}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_result"}, bus.result_o, e.res);
          check({e.name, "_latency"}, 32'(cyc - e.issue + 1), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int holds = 0;
    bit seen  = 1'b0;
    @(negedge clk);
    bus.valid_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    sb_q.push_back('{name, exp, lat, cyc});
    last_res = exp;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (bus.result_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.multdiv_hold_flag_o === 1'b1) holds++;
      @(negedge clk);
    end
    if (seen) begin
      check({name, "_hold_cycles"}, 32'(holds), 32'(lat - 1));
      check({name, "_hold_in_done"}, {31'b0, bus.multdiv_hold_flag_o}, 32'd0);
    end else begin
      check({name, "_timeout"}, {31'b0, bus.result_valid_o}, 32'd1);
    end
    bus.valid_i = 1'b0;
  endtask

  initial begin
    int c0;
    rst              = 1'b1;
    bus.valid_i      = 1'b0;
    bus.op_i         = 3'd0;
    bus.rs1_data_i   = '0;
    bus.rs2_data_i   = '0;
    bus.clean_flag_i = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_result", bus.result_o, 32'h0);
    check("reset_valid", {31'b0, bus.result_valid_o}, 32'd0);
    check("reset_hold", {31'b0, bus.multdiv_hold_flag_o}, 32'd0);
    rst = 1'b0;

    run_op("mul_7_m3",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_min_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhsu_m1_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mulhu_max_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    run_op("divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        34);
    run_op("remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         34);
    run_op("div_7_m2",      3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2",      3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op("div_5_0",       3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    run_op("remu_5_0",      3'd7, 32'd5,         32'd0,         32'd5,         2);
    run_op("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

    // Flush during the tenth iteration: no pulse, result kept
    @(negedge clk);
    bus.valid_i    = 1'b1;
    bus.op_i       = 3'd0;
    bus.rs1_data_i = 32'd5;
    bus.rs2_data_i = 32'd6;
    c0 = cyc;
    repeat (10) @(negedge clk);
    check("clean_hold_before", {31'b0, bus.multdiv_hold_flag_o}, 32'd1);
    bus.clean_flag_i = 1'b1;
    #1;
    check("clean_hold_drop", {31'b0, bus.multdiv_hold_flag_o}, 32'd0);
    @(negedge clk);
    bus.clean_flag_i = 1'b0;
    bus.valid_i      = 1'b0;
    check("clean_no_pulse", {31'b0, bus.result_valid_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("clean_result_kept", bus.result_o, last_res);
    check("clean_cycles_elapsed", 32'(cyc - c0), 32'd51);
    run_op("mul_after_clean", 3'd0, 32'd9, 32'd11, 32'd99, 34);

    // Reset during the twentieth iteration
    @(negedge clk);
    bus.valid_i    = 1'b1;
    bus.op_i       = 3'd5;
    bus.rs1_data_i = 32'd1000;
    bus.rs2_data_i = 32'd3;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("midrst_result", bus.result_o, 32'h0);
    check("midrst_valid", {31'b0, bus.result_valid_o}, 32'd0);
    check("midrst_hold", {31'b0, bus.multdiv_hold_flag_o}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    repeat (5) @(negedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
